// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
//   state_t    : arbiter FSM states
//   PORT_A/B   : requester ids (A = instruction fetch, B = data)
//   PRIO_RR/FIXED : arbitration mode selectors
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int unsigned PRIO_RR    = 0;
    localparam int unsigned PRIO_FIXED = 1;

    localparam int unsigned AW_DEF = 16;
    localparam int unsigned DW_DEF = 16;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of requester handshakes (ports A and B) and the RAM control bus.
//   slave  : arbiter side (consumes requests, drives acks and RAM controls)
//   master : requester/RAM side
interface ram_arbiter_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
);
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_ack;
    logic [DW-1:0] a_rdata;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_ack;
    logic [DW-1:0] b_rdata;

    logic          ram_wen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    logic          busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  ram_dout,
        output a_ack, a_rdata, b_ack, b_rdata,
        output ram_wen, ram_addr, ram_din, busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output ram_dout,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  ram_wen, ram_addr, ram_din, busy
    );
endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational two-way grant picker.
//   req[1:0]  : requests (bit 0 = port A, bit 1 = port B)
//   last      : port granted most recently
//   mode      : 0 = round-robin, 1 = fixed priority (A wins)
//   excl[1:0] : requests to ignore this cycle
//   gnt_valid : some eligible request exists
//   gnt_id    : winning port id
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       mode,
    input  logic [1:0] excl,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic [1:0] elig;

    // On a tie, fixed mode favours A; round-robin favours the port not served last.
    always_comb begin
        elig      = req & ~excl;
        gnt_valid = |elig;
        gnt_id    = PORT_A;
        if (&elig) begin
            gnt_id = mode ? PORT_A : ~last;
        end else if (elig[1]) begin
            gnt_id = PORT_B;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a single-port RAM between port A (fetch) and port B (data).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester handshakes, RAM controls and busy flag
// Every access takes IDLE/DONE -> ACCESS -> DONE; DONE can grant the other port
// directly so alternating traffic runs at one access per two cycles.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned PRIO_MODE = PRIO_RR
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_arbiter_if.slave  bus
);

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic          last_q, last_d;
    logic          wen_q, wen_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic          a_ack_q, a_ack_d;
    logic          b_ack_q, b_ack_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;
    logic          busy_q, busy_d;

    logic [1:0]    pick_excl;
    logic          gnt_valid;
    logic          gnt_id;

    // In DONE the just-served port still holds req for one cycle; mask it.
    assign pick_excl = (state_q == DONE) ? ((sel_q == PORT_B) ? 2'b10 : 2'b01) : 2'b00;

    rr_pick2 u_pick (
        .req       ({bus.b_req, bus.a_req}),
        .last      (last_q),
        .mode      (PRIO_MODE == PRIO_FIXED),
        .excl      (pick_excl),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        wen_d     = 1'b0;
        addr_d    = addr_q;
        din_d     = din_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (gnt_valid) begin
                    state_d = ACCESS;
                    sel_d   = gnt_id;
                    last_d  = gnt_id;
                    if (gnt_id == PORT_A) begin
                        wen_d  = bus.a_we;
                        addr_d = bus.a_addr;
                        din_d  = bus.a_wdata;
                    end else begin
                        wen_d  = bus.b_we;
                        addr_d = bus.b_addr;
                        din_d  = bus.b_wdata;
                    end
                end
            end
            ACCESS: begin
                state_d = DONE;
                if (sel_q == PORT_A) begin
                    a_ack_d = 1'b1;
                    if (!wen_q) a_rdata_d = bus.ram_dout;
                end else begin
                    b_ack_d = 1'b1;
                    if (!wen_q) b_rdata_d = bus.ram_dout;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; last grant resets to B so A wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= PORT_A;
            last_q    <= PORT_B;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.ram_wen  = wen_q;
    assign bus.ram_addr = addr_q;
    assign bus.ram_din  = din_q;
    assign bus.a_ack    = a_ack_q;
    assign bus.b_ack    = b_ack_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;
    assign bus.busy     = busy_q;

endmodule
